// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: USB full-speed transmit bit engine. Shifts bytes out LSB
// first, inserts a stuffed 0 after six consecutive ones, NRZI-encodes the line
// and appends SE0 SE0 J as the end of packet.
//
// Byte handshake with the packet controller: bytecomplete pulses on the first
// clk of data bit 7. The controller then has CLKS_PER_BIT-1 clks to present
// either tx_byte (send_eop=0) or send_eop=1. Both are sampled on the last clk
// of bit 7, the edge where prev_parallel captures the finished byte.
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       timer_en,
    input  logic [7:0] tx_byte,
    input  logic       send_eop,
    output logic       bytecomplete,
    output logic       bit_stuff_en,
    output logic [7:0] prev_parallel,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_busy,
    output logic       eop_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, EOP_SE0A, EOP_SE0B, EOP_J} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;            // clk position inside a bit period
    logic [7:0]       byte_q, byte_d;          // byte being transmitted
    logic [2:0]       idx_q, idx_d;            // current (or pending, during a stuff bit) data bit
    logic [2:0]       ones_q, ones_d;          // consecutive data ones
    logic             lvl_q, lvl_d;            // NRZI level, 1 = J
    logic             stuff_q, stuff_d;        // current period is a stuffed bit
    logic             eop_pend_q, eop_pend_d;  // EOP requested, waiting behind a stuff bit
    logic             bytecomplete_q, bytecomplete_d;
    logic [7:0]       prev_q, prev_d;
    logic             dp_q, dp_d;
    logic             dm_q, dm_d;
    logic             busy_q, busy_d;
    logic             eop_done_q, eop_done_d;

    logic             at_wrap;
    logic             send_data;
    logic             send_stuff;
    logic             data_bit;
    logic             base_lvl;
    logic [2:0]       base_ones;
    logic [2:0]       next_idx;

    // State and output registers; reset puts the line at idle J.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            byte_q         <= '0;
            idx_q          <= '0;
            ones_q         <= '0;
            lvl_q          <= 1'b1;
            stuff_q        <= 1'b0;
            eop_pend_q     <= 1'b0;
            bytecomplete_q <= 1'b0;
            prev_q         <= '0;
            dp_q           <= 1'b1;
            dm_q           <= 1'b0;
            busy_q         <= 1'b0;
            eop_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            byte_q         <= byte_d;
            idx_q          <= idx_d;
            ones_q         <= ones_d;
            lvl_q          <= lvl_d;
            stuff_q        <= stuff_d;
            eop_pend_q     <= eop_pend_d;
            bytecomplete_q <= bytecomplete_d;
            prev_q         <= prev_d;
            dp_q           <= dp_d;
            dm_q           <= dm_d;
            busy_q         <= busy_d;
            eop_done_q     <= eop_done_d;
        end
    end

    // Next state: decide what the next bit period carries at each bit boundary.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        byte_d         = byte_q;
        idx_d          = idx_q;
        ones_d         = ones_q;
        lvl_d          = lvl_q;
        stuff_d        = stuff_q;
        eop_pend_d     = eop_pend_q;
        prev_d         = prev_q;
        dp_d           = dp_q;
        dm_d           = dm_q;
        bytecomplete_d = 1'b0;
        eop_done_d     = 1'b0;
        at_wrap        = (cnt_q == CNT_LAST);
        send_data      = 1'b0;
        send_stuff     = 1'b0;
        data_bit       = 1'b0;
        base_lvl       = lvl_q;
        base_ones      = ones_q;
        // A stuff bit does not consume a data index, so the pending index is reused.
        next_idx       = stuff_q ? idx_q : idx_q + 3'd1;

        if (state_q != IDLE) begin
            cnt_d = at_wrap ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (timer_en) begin
                    state_d    = SHIFT;
                    cnt_d      = '0;
                    byte_d     = tx_byte;
                    idx_d      = '0;
                    eop_pend_d = 1'b0;
                    stuff_d    = 1'b0;
                    base_lvl   = 1'b1;
                    base_ones  = '0;
                    send_data  = 1'b1;
                    data_bit   = tx_byte[0];
                end
            end
            SHIFT: begin
                if (at_wrap) begin
                    stuff_d = 1'b0;
                    if (!stuff_q && idx_q == 3'd7) begin
                        // End of bit 7: byte handshake point.
                        prev_d = byte_q;
                        idx_d  = '0;
                        if (send_eop) begin
                            eop_pend_d = 1'b1;
                        end else begin
                            byte_d = tx_byte;
                        end
                        if (ones_q == 3'd6) begin
                            send_stuff = 1'b1;
                        end else if (send_eop) begin
                            state_d = EOP_SE0A;
                        end else begin
                            send_data = 1'b1;
                            data_bit  = tx_byte[0];
                        end
                    end else begin
                        idx_d = next_idx;
                        if (ones_q == 3'd6) begin
                            send_stuff = 1'b1;
                        end else if (eop_pend_q) begin
                            state_d = EOP_SE0A;
                        end else begin
                            send_data      = 1'b1;
                            data_bit       = byte_q[next_idx];
                            bytecomplete_d = (next_idx == 3'd7);
                        end
                    end
                end
            end
            EOP_SE0A: begin
                if (at_wrap) state_d = EOP_SE0B;
            end
            EOP_SE0B: begin
                if (at_wrap) begin
                    state_d = EOP_J;
                    dp_d    = 1'b1;
                    dm_d    = 1'b0;
                end
            end
            EOP_J: begin
                if (at_wrap) begin
                    state_d    = IDLE;
                    lvl_d      = 1'b1;
                    eop_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == SHIFT && state_d == EOP_SE0A) begin
            dp_d       = 1'b0;
            dm_d       = 1'b0;
            eop_pend_d = 1'b0;
        end

        if (send_stuff) begin
            stuff_d = 1'b1;
            ones_d  = '0;
            lvl_d   = ~lvl_q;
            dp_d    = ~lvl_q;
            dm_d    = lvl_q;
        end

        if (send_data) begin
            lvl_d  = data_bit ? base_lvl : ~base_lvl;
            ones_d = data_bit ? base_ones + 3'd1 : 3'd0;
            dp_d   = lvl_d;
            dm_d   = ~lvl_d;
        end

        // Abort: dropping timer_en mid-packet returns straight to idle J.
        if (state_q != IDLE && !timer_en) begin
            state_d        = IDLE;
            cnt_d          = '0;
            byte_d         = byte_q;
            idx_d          = idx_q;
            ones_d         = '0;
            lvl_d          = 1'b1;
            stuff_d        = 1'b0;
            eop_pend_d     = 1'b0;
            prev_d         = prev_q;
            dp_d           = 1'b1;
            dm_d           = 1'b0;
            bytecomplete_d = 1'b0;
            eop_done_d     = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign bytecomplete  = bytecomplete_q;
    assign bit_stuff_en  = stuff_q;
    assign prev_parallel = prev_q;
    assign dplus_out     = dp_q;
    assign dminus_out    = dm_q;
    assign tx_busy       = busy_q;
    assign eop_done      = eop_done_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb_usb_tx_serializer: packet table with hand-derived per-bit-period line
// symbols and events, plus directed abort and mid-packet reset sequences.
module tb_usb_tx_serializer;

    localparam int         CPB  = 4;
    localparam logic [7:0] GARB = 8'hA5;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       timer_en;
    logic [7:0] tx_byte;
    logic       send_eop;
    logic       bytecomplete;
    logic       bit_stuff_en;
    logic [7:0] prev_parallel;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_busy;
    logic       eop_done;

    int n_checks = 0;
    int n_pass   = 0;

    // line: one char per bit period (J, K, 0 = SE0); evt: S = stuffed bit, B = bytecomplete
    typedef struct {
        string      name;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        string      line;
        string      evt;
        logic [7:0] prev;
    } pkt_t;

    pkt_t pkts[4];
    logic [5:0] exp_q[$];  // {dplus, dminus, bit_stuff_en, bytecomplete, tx_busy, eop_done}

    usb_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .timer_en      (timer_en),
        .tx_byte       (tx_byte),
        .send_eop      (send_eop),
        .bytecomplete  (bytecomplete),
        .bit_stuff_en  (bit_stuff_en),
        .prev_parallel (prev_parallel),
        .dplus_out     (dplus_out),
        .dminus_out    (dminus_out),
        .tx_busy       (tx_busy),
        .eop_done      (eop_done)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [1:0] sym(input byte c);
        if (c == "J") return 2'b10;
        if (c == "K") return 2'b01;
        return 2'b00;
    endfunction

    task automatic set_pkt(input int i, input string name, input int nb, input logic [7:0] b0,
                           input logic [7:0] b1, input string line, input string evt,
                           input logic [7:0] prev);
        pkts[i].name   = name;
        pkts[i].nbytes = nb;
        pkts[i].b0     = b0;
        pkts[i].b1     = b1;
        pkts[i].line   = line;
        pkts[i].evt    = evt;
        pkts[i].prev   = prev;
    endtask

    // Driver + scoreboard for one packet; called on a negedge with the DUT idle.
    task automatic run_packet(input pkt_t p);
        int         nper;
        int         sent;
        int         due;
        logic [5:0] e;
        logic [5:0] a;
        logic [1:0] s;
        nper = p.line.len();
        exp_q.delete();
        for (int k = 0; k < nper * CPB; k++) begin
            s = sym(p.line[k / CPB]);
            exp_q.push_back({s, p.evt[k / CPB] == "S",
                             (p.evt[k / CPB] == "B") && (k % CPB == 0), 1'b1, 1'b0});
        end
        exp_q.push_back(6'b10_0001);
        exp_q.push_back(6'b10_0000);

        sent     = 1;
        due      = -1;
        tx_byte  = p.b0;
        send_eop = 1'b0;
        timer_en = 1'b1;
        for (int k = 0; k < nper * CPB + 2; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            a = {dplus_out, dminus_out, bit_stuff_en, bytecomplete, tx_busy, eop_done};
            check($sformatf("%s clk%0d", p.name, k), 32'(a), 32'(e));
            if (k == nper * CPB) begin
                check({p.name, " prev"}, 32'(prev_parallel), 32'(p.prev));
                timer_en = 1'b0;
            end
            if (k == 0) tx_byte = GARB;
            if (k == due) begin
                if (sent < p.nbytes) begin
                    tx_byte = p.b1;
                    sent++;
                end else begin
                    send_eop = 1'b1;
                end
            end else if (due >= 0 && k == due + 1) begin
                tx_byte  = GARB;
                send_eop = 1'b0;
                due      = -1;
            end
            if (bytecomplete) due = k + CPB - 1;
        end
        tx_byte  = GARB;
        send_eop = 1'b0;
    endtask

    // Main sequence.
    initial begin
        int glitches;
        set_pkt(0, "sync80", 1, 8'h80, 8'h00, "KJKJKJKK00J", ".......B...", 8'h80);
        set_pkt(1, "ff_00", 2, 8'hFF, 8'h00, "JJJJJJKKKJKJKJKJK00J",
                "......S.B.......B...", 8'h00);
        set_pkt(2, "c0_0f", 2, 8'hC0, 8'h0F, "KJKJKJJJJJJJKJKJK00J",
                ".......B....S...B...", 8'h0F);
        set_pkt(3, "fc_eop", 1, 8'hFC, 8'h00, "KJJJJJJJK00J", ".......BS...", 8'hFC);

        n_rst    = 1'b0;
        timer_en = 1'b0;
        send_eop = 1'b0;
        tx_byte  = 8'h00;
        repeat (2) @(negedge clk);
        check("reset outs", 32'({dplus_out, dminus_out, bit_stuff_en, bytecomplete, tx_busy, eop_done}),
              32'(6'b10_0000));
        check("reset prev", 32'(prev_parallel), 32'h00);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle outs", 32'({dplus_out, dminus_out, bit_stuff_en, bytecomplete, tx_busy, eop_done}),
              32'(6'b10_0000));

        for (int i = 0; i < 4; i++) begin
            run_packet(pkts[i]);
            repeat (2) @(negedge clk);
        end

        // Abort during bit 3 of 0x55 (line J K K J).
        tx_byte  = 8'h55;
        send_eop = 1'b0;
        timer_en = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) tx_byte = GARB;
            if (k == 1)  check("abort p0", 32'({dplus_out, dminus_out}), 32'(2'b10));
            if (k == 5)  check("abort p1", 32'({dplus_out, dminus_out}), 32'(2'b01));
            if (k == 9)  check("abort p2", 32'({dplus_out, dminus_out}), 32'(2'b01));
            if (k == 13) check("abort p3", 32'({dplus_out, dminus_out, tx_busy}), 32'(3'b101));
        end
        timer_en = 1'b0;
        @(negedge clk);
        check("abort outs", 32'({dplus_out, dminus_out, bit_stuff_en, bytecomplete, tx_busy, eop_done}),
              32'(6'b10_0000));
        check("abort prev", 32'(prev_parallel), 32'hFC);
        glitches = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (eop_done || bytecomplete || tx_busy || !dplus_out || dminus_out) glitches++;
        end
        check("abort quiet", 32'(glitches), 32'd0);

        // Reset in the middle of the stuffed bit of 0xFF.
        tx_byte  = 8'hFF;
        timer_en = 1'b1;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (k == 0) tx_byte = GARB;
        end
        check("pre-rst stuff", 32'({dplus_out, dminus_out, bit_stuff_en, tx_busy}), 32'(4'b0111));
        check("pre-rst prev", 32'(prev_parallel), 32'hFC);
        n_rst    = 1'b0;
        timer_en = 1'b0;
        #1;
        check("mid rst outs", 32'({dplus_out, dminus_out, bit_stuff_en, bytecomplete, tx_busy, eop_done}),
              32'(6'b10_0000));
        check("mid rst prev", 32'(prev_parallel), 32'h00);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post rst idle", 32'({dplus_out, dminus_out, tx_busy}), 32'(3'b100));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
